// File: rtl/bkg_write_scheduler.sv
// bkg_write_scheduler: round-robin pixel-write FIFO drained into backgroundRAM in vblank.
// Optional feature macro BKG_WR_COALESCE_EN merges repeat writes to the tail address.
module bkg_write_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 5,
  parameter int DEPTH    = 8,
  parameter int MAX_ADDR = 76800
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      vblank,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_write_address,
  output logic [DATA_W-1:0]         ram_data_In,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy,
  output logic                      err_oob
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] MAX_A = (ADDR_W+1)'(MAX_ADDR);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q, tail_last;
  logic [CW-1:0]     count_q, count_d;
  logic [RW-1:0]     rr_q, win;
  logic              found, empty, full, pop;
  logic              accept, oob, merge, push;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;

  function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RW'(s);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = (state_q == DRAIN) && vblank && !empty;
  assign tail_last = tail_q - 1'b1;

  // round-robin scan starting at rr_q, first valid requester wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(rr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_q, k);
      end
    end
  end

  assign sel_addr  = req_addr[win*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[win*DATA_W +: DATA_W];
  assign accept    = Reset_n && found && (!full || pop);
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
  assign oob       = ({1'b0, sel_addr} >= MAX_A);

`ifdef BKG_WR_COALESCE_EN
  // newest entry sits at tail-1; it is the popped one only when it is alone
  assign merge = accept && !oob && !empty
              && !(pop && count_q == CW'(1))
              && (mem_addr_q[tail_last] == sel_addr);
`else
  assign merge = 1'b0;
`endif

  assign push = accept && !oob && !merge;

  // occupancy next-state; push and pop together leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= sel_addr;
      mem_data_q[tail_q] <= sel_data;
    end else if (merge) begin
      mem_data_q[tail_last] <= sel_data;
    end
  end

  // FIFO pointers, occupancy, arbiter pointer and sticky error
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (accept) begin
        rr_q <= (win == RW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        if (oob) err_q <= 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // drain only in vblank; leave as soon as vblank drops or FIFO empties
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (vblank && !empty) state_d = DRAIN;
      DRAIN: if (!vblank || count_d == '0) state_d = IDLE;
    endcase
  end

  // popped head is registered onto the RAM port for a one-cycle write
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        wa_q <= mem_addr_q[head_q];
        wd_q <= mem_data_q[head_q];
      end
    end
  end

  assign ram_we            = we_q;
  assign ram_write_address = wa_q;
  assign ram_data_In       = wd_q;
  assign fifo_count        = count_q;
  assign busy              = (state_q == DRAIN);
  assign err_oob           = err_q;

endmodule

// File: tb/tb_bkg_write_scheduler.sv
// tb_bkg_write_scheduler: table vectors, corner sequences and a queue-based
// reference model with random stimulus for bkg_write_scheduler.
module tb_bkg_write_scheduler;
  localparam int N    = 4;
  localparam int AW   = 17;
  localparam int DW   = 5;
  localparam int D    = 8;
  localparam int MAXA = 76800;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            vblank = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            ram_we;
  logic [AW-1:0]   ram_write_address;
  logic [DW-1:0]   ram_data_In;
  logic [3:0]      fifo_count;
  logic            busy;
  logic            err_oob;

  bkg_write_scheduler dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .vblank(vblank),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .ram_we(ram_we),
    .ram_write_address(ram_write_address),
    .ram_data_In(ram_data_In),
    .fifo_count(fifo_count),
    .busy(busy),
    .err_oob(err_oob)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [N-1:0] v;
    bit           vb;
    logic [N-1:0] rdy;
    int           cnt;
    bit           bsy;
    bit           we;
    int           ent;
  } row_t;

  int total = 0;
  int bad = 0;

  // requester stimulus
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  bit            vb;
  logic [AW-1:0] A0 [N];
  logic [DW-1:0] D0 [N];

  // reference model
  ent_t mq[$];
  int   m_rr;
  bit   m_drain;
  bit   m_we;
  ent_t m_w;
  bit   m_err;
  int   m_acc;

  // values sampled at the last negedge
  logic [N-1:0]  s_ready;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  int            s_cnt;
  logic          s_busy;
  logic          s_err;
  int            wr_count;
  ent_t          wlog[$];

  row_t tab [21];
  int   vb_left;
  int   exp_n;
  ent_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    m_rr = 0;
    m_drain = 0;
    m_we = 0;
    m_w = '0;
    m_err = 0;
    m_acc = -1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
    vblank = vb;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = int'($urandom % 16);
    if (r < 10) return AW'(200 + r % 3);
    if (r < 15) return AW'($urandom_range(0, MAXA - 1));
    return AW'(MAXA + int'($urandom % 5));
  endfunction

  // one clock: drive, check at negedge against the model, advance the model
  task automatic cyc();
    int           w;
    bit           pop;
    bit           can;
    bit           mrg;
    int           sz0;
    logic [N-1:0] er;
    ent_t         t;
    drive();
    @(negedge Clk);
    pop = m_drain && vb && (mq.size() > 0);
    can = (mq.size() < D) || pop;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
    end
    if (!can) w = -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    s_ready = req_ready;
    s_we = ram_we;
    s_addr = ram_write_address;
    s_data = ram_data_In;
    s_cnt = int'(fifo_count);
    s_busy = busy;
    s_err = err_oob;
    chk("ready", req_ready, er);
    chk("we", ram_we, m_we);
    if (m_we) begin
      chk("waddr", ram_write_address, m_w.addr);
      chk("wdata", ram_data_In, m_w.data);
    end
    chk("count", fifo_count, mq.size());
    chk("busy", busy, m_drain);
    chk("err_oob", err_oob, m_err);
    if (ram_we) begin
      wr_count++;
      t.addr = ram_write_address;
      t.data = ram_data_In;
      wlog.push_back(t);
    end
    @(posedge Clk);
    sz0 = mq.size();
    m_we = 0;
    if (pop) begin
      m_w = mq.pop_front();
      m_we = 1;
    end
    m_acc = w;
    if (w >= 0) begin
      m_rr = (w + 1) % N;
      if (int'(a[w]) >= MAXA) m_err = 1;
      else begin
        mrg = 0;
`ifdef BKG_WR_COALESCE_EN
        if (mq.size() > 0 && mq[mq.size()-1].addr == a[w]) mrg = 1;
`endif
        if (mrg) begin
          t = mq.pop_back();
          t.data = d[w];
          mq.push_back(t);
        end else begin
          t.addr = a[w];
          t.data = d[w];
          mq.push_back(t);
        end
      end
    end
    if (m_drain) m_drain = vb && (mq.size() > 0);
    else         m_drain = vb && (sz0 > 0);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      A0[i] = AW'(1000 + i * 37);
      D0[i] = DW'(i + 3);
      a[i] = A0[i];
      d[i] = D0[i];
    end
    for (int r = 0; r < 8; r++)
      tab[r] = '{4'hF, 1'b0, 4'(1 << (r % 4)), r, 1'b0, 1'b0, -1};
    tab[8]  = '{4'hF, 1'b0, 4'h0, 8, 1'b0, 1'b0, -1};
    tab[9]  = '{4'hF, 1'b0, 4'h0, 8, 1'b0, 1'b0, -1};
    tab[10] = '{4'h0, 1'b1, 4'h0, 8, 1'b0, 1'b0, -1};
    tab[11] = '{4'h0, 1'b1, 4'h0, 8, 1'b1, 1'b0, -1};
    for (int j = 0; j < 7; j++)
      tab[12+j] = '{4'h0, 1'b1, 4'h0, 7 - j, 1'b1, 1'b1, j};
    tab[19] = '{4'h0, 1'b1, 4'h0, 0, 1'b0, 1'b1, 7};
    tab[20] = '{4'h0, 1'b1, 4'h0, 0, 1'b0, 1'b0, -1};

    // reset state, with requests pending to show grants are held off
    v = 4'hF;
    vb = 1'b0;
    drive();
    reset_model();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_oob, 0);
    v = '0;
    drive();
    #2 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // fill under backpressure, then drain in accept order
    for (int r = 0; r < 21; r++) begin
      v = tab[r].v;
      vb = tab[r].vb;
      cyc();
      chk($sformatf("tab%0d_ready", r), s_ready, tab[r].rdy);
      chk($sformatf("tab%0d_cnt", r), s_cnt, tab[r].cnt);
      chk($sformatf("tab%0d_busy", r), s_busy, tab[r].bsy);
      chk($sformatf("tab%0d_we", r), s_we, tab[r].we);
      if (tab[r].ent >= 0) begin
        chk($sformatf("tab%0d_addr", r), s_addr, A0[tab[r].ent % N]);
        chk($sformatf("tab%0d_data", r), s_data, D0[tab[r].ent % N]);
      end
    end

    // vblank falls after three pops, then drain resumes
    v = 4'hF;
    vb = 1'b0;
    repeat (8) cyc();
    v = '0;
    wr_count = 0;
    vb = 1'b1;
    repeat (4) cyc();
    vb = 1'b0;
    repeat (4) cyc();
    chk("fall_writes", wr_count, 3);
    chk("fall_left", s_cnt, 5);
    vb = 1'b1;
    repeat (12) cyc();
    chk("resume_writes", wr_count, 8);
    chk("resume_empty", s_cnt, 0);

    // out-of-range address is accepted but never stored
    vb = 1'b0;
    v = 4'b0100;
    a[2] = AW'(MAXA);
    d[2] = 5'h1F;
    cyc();
    chk("oob_ready", s_ready, 4'b0100);
    v = '0;
    cyc();
    chk("oob_err", s_err, 1);
    chk("oob_cnt", s_cnt, 0);
    wr_count = 0;
    vb = 1'b1;
    repeat (4) cyc();
    chk("oob_nowrite", wr_count, 0);
    a[2] = A0[2];
    d[2] = D0[2];

    // two writes to one address
    vb = 1'b0;
    v = 4'b0001;
    a[0] = AW'(100);
    d[0] = DW'(3);
    cyc();
    d[0] = DW'(7);
    cyc();
    v = '0;
    cyc();
`ifdef BKG_WR_COALESCE_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    chk("same_addr_cnt", s_cnt, exp_n);
    wlog.delete();
    vb = 1'b1;
    repeat (5) cyc();
    chk("same_addr_nwr", wlog.size(), exp_n);
    if (wlog.size() == exp_n) begin
      e = wlog[exp_n-1];
      chk("same_addr_last_a", e.addr, 100);
      chk("same_addr_last_d", e.data, 7);
      if (exp_n == 2) begin
        e = wlog[0];
        chk("same_addr_first_d", e.data, 3);
      end
    end
    a[0] = A0[0];
    d[0] = D0[0];

    // reset in the middle of a drain
    vb = 1'b0;
    v = 4'hF;
    repeat (3) cyc();
    v = '0;
    cyc();
    chk("mid_fill", s_cnt, 3);
    vb = 1'b1;
    cyc();
    cyc();
    chk("mid_we_pre", ram_we, 1);
    v = 4'hF;
    drive();
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    v = '0;
    vb = 1'b0;
    drive();
    reset_model();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    repeat (3) cyc();
    chk("mid_idle", s_busy, 0);

    // random traffic against the model
    vb = 1'b0;
    vb_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (vb_left == 0) begin
        vb = ~vb;
        vb_left = int'($urandom_range(3, 30));
      end
      vb_left--;
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1'b1;
          a[i] = rand_addr();
          d[i] = DW'($urandom);
        end
      end
      cyc();
      if (m_acc >= 0) v[m_acc] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bkg_write_scheduler.md
Name: bkg_write_scheduler

Overview:
- Shares the single write port of backgroundRAM between NUM_REQ game-logic requesters (for example decals, damage marks, tile changes).
- Accepts pixel writes at any time into a small FIFO through a round-robin arbiter.
- Drains the FIFO into the RAM only while the VGA is in vertical blank, so the display read path never sees mid-frame updates.
- Sits beside backgroundRAM and drives its we, write_address and data_In.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 17, write address width; 320x240 = 76800 pixels.
- DATA_W, 5, palette index width.
- DEPTH, 8, FIFO entries; must be a power of 2.
- MAX_ADDR, 76800, first illegal address.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- vblank  in  1  high when RAM writes are permitted; synchronous to Clk.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened palette indices.
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted in any cycle where valid and ready are both high.
- ram_we  out  1  backgroundRAM write enable.
- ram_write_address  out  ADDR_W  RAM write address.
- ram_data_In  out  DATA_W  RAM write data.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- busy  out  1  high when the FSM is in DRAIN.
- err_oob  out  1  sticky flag: an out-of-range address was received.

Behaviour:

Reset (asynchronous, on Reset_n=0):
- All outputs are 0, FIFO is empty, round-robin pointer is 0, FSM is in IDLE.

Arbitration (combinational grant):
- Scan requesters starting at the pointer rr_ptr; the first one with valid high wins.
- A grant is issued only if the FIFO is not full, or if it is full and a pop occurs this same cycle.
- req_ready is one-hot on the winner and all-zero otherwise.
- On an accepted request, rr_ptr becomes (winner+1) mod NUM_REQ on the next edge. With no accept, rr_ptr holds.
- Requesters must hold valid, addr and data stable until accepted.

Push:
- An accepted entry {addr, data} is written at the tail on the same edge.
- If addr >= MAX_ADDR, the request is still accepted (ready high) but the entry is not pushed, and err_oob is set. err_oob clears only on reset.

FSM states:
- IDLE: ram_we=0. Go to DRAIN when vblank=1 and the FIFO is non-empty.
- DRAIN: each cycle, pop the head and register it onto the RAM outputs, with ram_we=1 in the following cycle.
  - Latency from pop to ram_we is 1 cycle; each ram_we pulse lasts exactly 1 cycle.
  - Return to IDLE when the FIFO becomes empty or vblank=0.
  - If vblank falls, no further pops occur, but an already registered write still completes in the next cycle.

Boundary rules:
- Simultaneous push and pop: count is unchanged; the full condition is relaxed for that cycle.
- Pop and push on an empty FIFO in the same cycle are not allowed: the entry is pushed first and popped the following cycle at the earliest.
- Pointers wrap modulo DEPTH. The count distinguishes full (count = DEPTH) from empty (count = 0).
- When vblank=0, no RAM write begins. Requests continue to be accepted until the FIFO is full, after which all req_ready are 0 (backpressure).
- Throughput: at most one accept and one RAM write per cycle.

Optional Feature:

Macro: BKG_WR_COALESCE_EN.
- When defined, an accepted request is coalesced into the tail entry (data overwritten, no push, count unchanged) if all of the following hold:
  - its address equals the address of the most recently pushed entry;
  - that entry is still in the FIFO;
  - that entry is not being popped this cycle.
- When undefined, every in-range accept pushes a new entry.

Test Plan:
- Reset mid-DRAIN with 3 entries queued: assert Reset_n=0 -> ram_we=0 immediately, fifo_count=0, req_ready=0; after release the FSM is in IDLE.
- vblank=0, requesters 0..3 all valid continuously, DEPTH=8 -> grants in order 0,1,2,3,0,1,2,3; fifo_count reaches 8 and req_ready stays 0; no ram_we pulse.
- vblank rises with 8 entries queued -> 8 consecutive ram_we pulses, the first 2 cycles after the rise, with addresses and data in accept order; busy drops after the last pop; fifo_count=0.
- vblank falls after 3 pops -> exactly 3 writes occur (the last one the cycle after the fall); 5 entries remain; draining resumes on the next vblank.
- Requester 2 sends addr=76800, data=5'h1F -> ready pulses, err_oob=1, fifo_count unchanged, and no RAM write ever occurs for it.
- With BKG_WR_COALESCE_EN: two accepts to addr=100 with data 3 then 7 -> fifo_count=1 and one RAM write of 7. Without the macro: fifo_count=2, writes of 3 then 7.
